// File: rtl/scsi_port_responder.sv
// SCSI-controller side of the SCSI_SM host port: strobe decode, indirect register file,
// DREQ_/DACK byte handshake and a byte FIFO toward a streaming back end.
module scsi_port_responder #(
   parameter int FIFO_DEPTH = 8,
   parameter int DREQ_LAT   = 2
) (
   input  logic       CPUCLK,
   input  logic       RESET_,
   input  logic       CS,
   input  logic       RE,
   input  logic       WE,
   input  logic       DACK,
   input  logic       A0,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       DOE,
   output logic       DREQ_,
   output logic       INT,
   input  logic [7:0] BK_IN_DATA,
   input  logic       BK_IN_VALID,
   output logic       BK_IN_READY,
   output logic [7:0] BK_OUT_DATA,
   output logic       BK_OUT_VALID,
   input  logic       BK_OUT_READY
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int LW = $clog2(DREQ_LAT + 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_HOLD, S_DONE} state_t;

   state_t          r_state;
   logic            r_re_q, r_we_q;
   logic            r_doe, r_dreq_n, r_int, r_done;
   logic [7:0]      r_dout;
   logic [1:0]      r_addr;
   logic            r_dmaen, r_dir;
   logic [15:0]     r_tc;
   logic [LW-1:0]   r_hold_cnt;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [CW-1:0]   r_cnt;

   logic w_re_edge, w_we_edge, w_dma_rd, w_dma_wr, w_reg_rd, w_reg_wr;
   logic w_full, w_empty, w_tc_nz, w_xfer, w_last, w_ctrl_wr, w_flush, w_en_clr;
   logic w_push, w_pop, w_req_ok, w_bk_in_ready, w_bk_out_valid;
   logic [7:0] w_push_data, w_head, w_rd_val;

   // One access per strobe: act only on the cycle a strobe first rises. DACK masks CS.
   assign w_re_edge = RE & ~r_re_q;
   assign w_we_edge = WE & ~r_we_q;
   assign w_dma_rd  = DACK & w_re_edge;
   assign w_dma_wr  = DACK & w_we_edge;
   assign w_reg_rd  = CS & ~DACK & w_re_edge;
   assign w_reg_wr  = CS & ~DACK & w_we_edge;

   assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_tc_nz   = (r_tc != 16'd0);
   assign w_head    = r_mem[r_rp];

   // Only a correctly-directed strobe with FIFO room/data and TC left moves a byte.
   assign w_xfer    = r_dmaen & w_tc_nz &
                      (r_dir ? (w_dma_wr & ~w_full) : (w_dma_rd & ~w_empty));
   assign w_last    = w_xfer & (r_tc == 16'd1);
   assign w_ctrl_wr = w_reg_wr & A0 & (r_addr == 2'd0);
   assign w_flush   = w_ctrl_wr & (DIN[0] != r_dir);
   assign w_en_clr  = w_ctrl_wr & ~DIN[1];
   assign w_req_ok  = r_dmaen & w_tc_nz & (r_dir ? ~w_full : ~w_empty);

   assign w_bk_in_ready  = r_dmaen & ~r_dir & ~w_full;
   assign w_bk_out_valid = r_dir & ~w_empty;
   assign w_push      = r_dir ? w_xfer : (BK_IN_VALID & w_bk_in_ready);
   assign w_pop       = r_dir ? (w_bk_out_valid & BK_OUT_READY) : w_xfer;
   assign w_push_data = r_dir ? DIN : BK_IN_DATA;

   always_comb begin
      w_rd_val = 8'h00;
      case (r_addr)
         2'd0: w_rd_val = {6'b0, r_dmaen, r_dir};
         2'd1: w_rd_val = r_tc[7:0];
         2'd2: w_rd_val = r_tc[15:8];
         default: w_rd_val = {5'b0, w_full, w_empty, r_done};
      endcase
   end

   always_ff @(posedge CPUCLK or negedge RESET_) begin
      if (!RESET_) begin
         r_re_q <= 1'b0;
         r_we_q <= 1'b0;
         r_doe  <= 1'b0;
         r_dout <= 8'h00;
      end else begin
         r_re_q <= RE;
         r_we_q <= WE;
         r_doe  <= RE & (CS | DACK);
         if (w_reg_rd)
            r_dout <= A0 ? w_rd_val : {6'b0, r_addr};
         else if (w_dma_rd & ~r_dir & ~w_empty)
            r_dout <= w_head;
      end
   end

   always_ff @(posedge CPUCLK or negedge RESET_) begin
      if (!RESET_) begin
         r_addr  <= 2'd0;
         r_dmaen <= 1'b0;
         r_dir   <= 1'b0;
         r_tc    <= 16'd0;
         r_done  <= 1'b0;
         r_int   <= 1'b0;
      end else begin
         if (w_reg_wr) begin
            if (!A0) begin
               r_addr <= DIN[1:0];
            end else begin
               case (r_addr)
                  2'd0: begin
                     r_dmaen <= DIN[1];
                     r_dir   <= DIN[0];
                  end
                  2'd1: r_tc[7:0]  <= DIN;
                  2'd2: r_tc[15:8] <= DIN;
                  default: ;
               endcase
               r_addr <= r_addr + 2'd1;
            end
         end
         if (w_reg_rd & A0) begin
            r_addr <= r_addr + 2'd1;
            if (r_addr == 2'd3) begin
               r_done <= 1'b0;
               r_int  <= 1'b0;
            end
         end
         if (w_xfer)
            r_tc <= r_tc - 16'd1;
         if (w_last) begin
            r_done  <= 1'b1;
            r_int   <= 1'b1;
            r_dmaen <= 1'b0;
         end
      end
   end

   always_ff @(posedge CPUCLK or negedge RESET_) begin
      if (!RESET_) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (w_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CPUCLK) begin
      if (w_push & ~w_flush)
         r_mem[r_wp] <= w_push_data;
   end

   // Request FSM; a final byte forces DONE from whatever state carried it.
   always_ff @(posedge CPUCLK or negedge RESET_) begin
      if (!RESET_) begin
         r_state    <= S_IDLE;
         r_dreq_n   <= 1'b1;
         r_hold_cnt <= '0;
      end else if (w_last) begin
         r_state  <= S_DONE;
         r_dreq_n <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: if (w_req_ok & ~w_en_clr) begin
               r_state  <= S_REQ;
               r_dreq_n <= 1'b0;
            end
            S_REQ: if (w_xfer) begin
               r_state  <= S_ACK;
               r_dreq_n <= 1'b1;
            end else if (~w_req_ok | w_en_clr) begin
               r_state  <= S_IDLE;
               r_dreq_n <= 1'b1;
            end
            S_ACK: if (~DACK & ~RE & ~WE) begin
               r_state    <= r_dmaen ? S_HOLD : S_IDLE;
               r_hold_cnt <= '0;
            end
            S_HOLD: begin
               if (~r_dmaen | (r_hold_cnt == LW'(DREQ_LAT - 1)))
                  r_state <= S_IDLE;
               else
                  r_hold_cnt <= r_hold_cnt + LW'(1);
            end
            default: begin
               r_state  <= S_IDLE;
               r_dreq_n <= 1'b1;
            end
         endcase
      end
   end

   assign DOUT         = r_dout;
   assign DOE          = r_doe;
   assign DREQ_        = r_dreq_n;
   assign INT          = r_int;
   assign BK_IN_READY  = w_bk_in_ready;
   assign BK_OUT_VALID = w_bk_out_valid;
   assign BK_OUT_DATA  = w_head;
endmodule
